// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Optional FETCH_STALL_COUNTER_EN adds o_stall_count, a saturating count of PC-stall cycles.
module fetch_stage #(
   parameter int unsigned                PC_BITS          = 32,
   parameter int unsigned                INSTRUCTION_BITS = 32,
   parameter logic [INSTRUCTION_BITS-1:0] HALT_OPCODE     = '1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_enable,
   input  logic                        i_PCWrite,
   input  logic                        i_if_id_write,
   input  logic                        i_flush,
   input  logic [PC_BITS-1:0]          i_branch_target,
   input  logic [INSTRUCTION_BITS-1:0] i_imem_data,
   output logic [PC_BITS-1:0]          o_imem_addr,
   output logic [PC_BITS-1:0]          o_pc,
   output logic [INSTRUCTION_BITS-1:0] o_if_id_instruction,
   output logic [PC_BITS-1:0]          o_if_id_pc_next,
   output logic                        o_if_id_valid,
   output logic                        o_halted
`ifdef FETCH_STALL_COUNTER_EN
   ,
   output logic [31:0]                 o_stall_count
`endif
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t             state;
   logic [PC_BITS-1:0] pc_plus4;
   logic               is_halt;

   assign pc_plus4    = o_pc + PC_BITS'(4);
   assign is_halt     = (i_imem_data == HALT_OPCODE);
   assign o_imem_addr = o_pc;
   assign o_halted    = (state == HALTED);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state               <= RUN;
         o_pc                <= '0;
         o_if_id_instruction <= '0;
         o_if_id_pc_next     <= '0;
         o_if_id_valid       <= 1'b0;
      end else if (i_enable) begin
         if (i_flush) begin
            state               <= RUN;
            o_pc                <= i_branch_target;
            o_if_id_instruction <= '0;
            o_if_id_pc_next     <= '0;
            o_if_id_valid       <= 1'b0;
         end else if (state == HALTED) begin
            o_if_id_instruction <= '0;
            o_if_id_pc_next     <= '0;
            o_if_id_valid       <= 1'b0;
         end else begin
            if (i_if_id_write) begin
               o_if_id_instruction <= i_imem_data;
               o_if_id_pc_next     <= pc_plus4;
               o_if_id_valid       <= 1'b1;
            end
            // Latching the halt word parks the PC on the halt address.
            if (i_if_id_write && is_halt) begin
               state <= HALTED;
            end else if (i_PCWrite) begin
               o_pc <= pc_plus4;
            end
         end
      end
   end

`ifdef FETCH_STALL_COUNTER_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_stall_count <= '0;
      end else if (i_enable && !i_flush && state == RUN && !i_PCWrite
                   && o_stall_count != '1) begin
         o_stall_count <= o_stall_count + 32'd1;
      end
   end
`endif

endmodule
